// File: rtl/fix_float_pkg.sv
// Shared types and constants for the fixed/float divider: FSM states, FP32 layout, special encodings.
package fix_float_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_UNPACK, S_SPECIAL, S_DIVIDE, S_NORM, S_ROUND, S_DONE
  } state_t;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } fp32_t;

  localparam int          BIAS    = 127;
  localparam logic [31:0] QNAN    = 32'h7FC00000;
  localparam logic [31:0] POS_INF = 32'h7F800000;
  localparam logic [31:0] FIX_MAX = 32'h7FFFFFFF;
  localparam logic [31:0] FIX_MIN = 32'h80000000;

endpackage

// File: rtl/fix_float_divider_fp32_round_ne.sv
// Round-to-nearest-even for a normalized 24-bit mantissa, then packs to FP32
// with overflow to signed infinity and flush of non-positive exponents to signed zero.
module fp32_round_ne
  import fix_float_pkg::*;
(
  input  logic              i_sign,
  input  logic [23:0]       i_mant,
  input  logic              i_guard,
  input  logic              i_round,
  input  logic              i_sticky,
  input  logic signed [9:0] i_exp,
  output logic [31:0]       o_y,
  output logic              o_ovf
);
  logic              w_inc;
  logic [24:0]       w_sum;
  logic [23:0]       w_mant;
  logic signed [9:0] w_exp;

  always_comb begin
    w_inc  = i_guard & (i_round | i_sticky | i_mant[0]);
    w_sum  = {1'b0, i_mant} + {24'd0, w_inc};
    w_mant = w_sum[24] ? w_sum[24:1] : w_sum[23:0];
    w_exp  = i_exp + (w_sum[24] ? 10'sd1 : 10'sd0);
    o_ovf  = 1'b0;
    o_y    = {i_sign, w_exp[7:0], w_mant[22:0]};
    if (w_exp >= 10'sd255) begin
      o_y   = {i_sign, POS_INF[30:0]};
      o_ovf = 1'b1;
    end else if (w_exp <= 10'sd0) begin
      o_y   = {i_sign, 31'd0};
    end
  end
endmodule

// File: rtl/fix_float_divider.sv
// Iterative restoring divider for FP32 and signed Q16.16 (one quotient bit per cycle).
// Define FIX_FLOAT_DIV_FIXED_EN to compile in the Q16.16 path; otherwise every operation is float.
module fix_float_divider
  import fix_float_pkg::*;
#(
  parameter int FIX_LAT_DIV = 48,
  parameter int FLT_LAT_DIV = 27
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        start_i,
  input  logic        mode_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        ready_o,
  output logic        valid_o,
  output logic [31:0] y_o,
  output logic        dz_o,
  output logic        inv_o,
  output logic        ovf_o
);
`ifdef FIX_FLOAT_DIV_FIXED_EN
  localparam int QW = 48;
`else
  localparam int QW = 27;
`endif
  localparam int CW = $clog2((FIX_LAT_DIV > FLT_LAT_DIV) ? FIX_LAT_DIV : FLT_LAT_DIV);

  state_t            r_state;
  fp32_t             r_a, r_b;
  logic              r_sign;
  logic [7:0]        r_ea, r_eb;
  logic [31:0]       r_opa, r_opb, r_rem;
  logic [QW-1:0]     r_dvd, r_q;
  logic [CW-1:0]     r_cnt;
  logic signed [9:0] r_exp;
  logic [23:0]       r_mant;
  logic              r_g, r_r, r_s;
  logic [31:0]       r_y;
  logic              r_valid, r_ready, r_dz, r_inv, r_ovf;
  logic              w_flt;
`ifdef FIX_FLOAT_DIV_FIXED_EN
  logic              r_mode;
  logic [31:0]       r_fy, w_fy;
  logic              r_fovf, w_fsat;
  assign w_flt = r_mode;
`else
  logic              w_unused_mode;
  assign w_flt         = 1'b1;
  assign w_unused_mode = mode_i;
`endif

  // Restoring step: shift next dividend bit into the partial remainder, subtract if it fits.
  logic [32:0] w_shift, w_sub;
  logic        w_ge;
  assign w_shift = {r_rem, r_dvd[QW-1]};
  assign w_ge    = w_shift >= {1'b0, r_opb};
  assign w_sub   = w_shift - {1'b0, r_opb};

  logic w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_nan;
  assign w_a_zero = (r_a.exp == 8'd0);
  assign w_b_zero = (r_b.exp == 8'd0);
  assign w_a_inf  = (&r_a.exp) & ~(|r_a.mant);
  assign w_b_inf  = (&r_b.exp) & ~(|r_b.mant);
  assign w_nan    = ((&r_a.exp) & (|r_a.mant)) | ((&r_b.exp) & (|r_b.mant));

  logic        w_spc, w_spc_dz, w_spc_inv;
  logic [31:0] w_spc_y;
  always_comb begin
    w_spc = 1'b0; w_spc_dz = 1'b0; w_spc_inv = 1'b0; w_spc_y = '0;
    if (w_flt) begin
      if (w_nan) begin
        w_spc = 1'b1; w_spc_y = QNAN;
      end else if ((w_a_zero & w_b_zero) | (w_a_inf & w_b_inf)) begin
        w_spc = 1'b1; w_spc_y = QNAN; w_spc_inv = 1'b1;
      end else if (w_b_zero & ~w_a_inf) begin
        w_spc = 1'b1; w_spc_y = {r_sign, POS_INF[30:0]}; w_spc_dz = 1'b1;
      end else if (w_a_inf) begin
        w_spc = 1'b1; w_spc_y = {r_sign, POS_INF[30:0]};
      end else if (w_a_zero | w_b_inf) begin
        w_spc = 1'b1; w_spc_y = {r_sign, 31'd0};
      end
    end
`ifdef FIX_FLOAT_DIV_FIXED_EN
    else if (r_opb == 32'd0) begin
      w_spc = 1'b1; w_spc_dz = 1'b1; w_spc_y = r_a.sign ? FIX_MIN : FIX_MAX;
    end
`endif
  end

  // Float normalization: quotient lies in [2^25, 2^27), so at most one left shift.
  logic [26:0]       w_q27;
  logic signed [9:0] w_exp;
  always_comb begin
    w_q27 = r_q[26:0];
    w_exp = $signed({2'b00, r_ea}) - $signed({2'b00, r_eb}) + 10'sd127;
    if (!w_q27[26]) begin
      w_q27 = {w_q27[25:0], 1'b0};
      w_exp = w_exp - 10'sd1;
    end
  end

`ifdef FIX_FLOAT_DIV_FIXED_EN
  always_comb begin
    w_fsat = r_sign ? (r_q > 48'h0000_8000_0000) : (r_q > 48'h0000_7FFF_FFFF);
    w_fy   = r_sign ? (32'd0 - r_q[31:0]) : r_q[31:0];
    if (w_fsat) w_fy = r_sign ? FIX_MIN : FIX_MAX;
  end
`endif

  logic [31:0] w_rnd_y;
  logic        w_rnd_ovf;
  fp32_round_ne u_rnd (
    .i_sign(r_sign), .i_mant(r_mant), .i_guard(r_g), .i_round(r_r), .i_sticky(r_s),
    .i_exp(r_exp), .o_y(w_rnd_y), .o_ovf(w_rnd_ovf)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= S_IDLE;
      r_a <= '0; r_b <= '0; r_sign <= 1'b0; r_ea <= '0; r_eb <= '0;
      r_opa <= '0; r_opb <= '0; r_rem <= '0; r_dvd <= '0; r_q <= '0; r_cnt <= '0;
      r_exp <= '0; r_mant <= '0; r_g <= 1'b0; r_r <= 1'b0; r_s <= 1'b0;
      r_y <= '0; r_valid <= 1'b0; r_ready <= 1'b1;
      r_dz <= 1'b0; r_inv <= 1'b0; r_ovf <= 1'b0;
`ifdef FIX_FLOAT_DIV_FIXED_EN
      r_mode <= 1'b1; r_fy <= '0; r_fovf <= 1'b0;
`endif
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: if (start_i) begin
          r_a <= a_i; r_b <= b_i; r_ready <= 1'b0; r_state <= S_UNPACK;
`ifdef FIX_FLOAT_DIV_FIXED_EN
          r_mode <= mode_i;
`endif
        end
        S_UNPACK: begin
          r_sign <= r_a.sign ^ r_b.sign;
          r_ea <= r_a.exp; r_eb <= r_b.exp;
          r_state <= S_SPECIAL;
`ifdef FIX_FLOAT_DIV_FIXED_EN
          if (!w_flt) begin
            r_opa <= r_a.sign ? 32'd0 - r_a : r_a;
            r_opb <= r_b.sign ? 32'd0 - r_b : r_b;
          end else
`endif
          begin
            r_opa <= w_a_zero ? 32'd0 : {8'd0, 1'b1, r_a.mant};
            r_opb <= w_b_zero ? 32'd0 : {8'd0, 1'b1, r_b.mant};
          end
        end
        S_SPECIAL: begin
          if (w_spc) begin
            r_y <= w_spc_y; r_dz <= w_spc_dz; r_inv <= w_spc_inv; r_ovf <= 1'b0;
            r_valid <= 1'b1; r_state <= S_DONE;
          end else begin
            r_q <= '0; r_state <= S_DIVIDE;
`ifdef FIX_FLOAT_DIV_FIXED_EN
            if (!w_flt) begin
              r_rem <= '0; r_dvd <= {r_opa, 16'd0}; r_cnt <= CW'(FIX_LAT_DIV - 1);
            end else
`endif
            begin
              // Preload so the first step sees the whole mantissa, then zeros shift in.
              r_rem <= {9'd0, r_opa[23:1]};
              r_dvd <= {r_opa[0], {(QW-1){1'b0}}};
              r_cnt <= CW'(FLT_LAT_DIV - 1);
            end
          end
        end
        S_DIVIDE: begin
          r_rem <= w_ge ? w_sub[31:0] : w_shift[31:0];
          r_dvd <= {r_dvd[QW-2:0], 1'b0};
          r_q   <= {r_q[QW-2:0], w_ge};
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) r_state <= S_NORM;
        end
        S_NORM: begin
          r_exp <= w_exp; r_mant <= w_q27[26:3];
          r_g <= w_q27[2]; r_r <= w_q27[1]; r_s <= w_q27[0] | (r_rem != 32'd0);
`ifdef FIX_FLOAT_DIV_FIXED_EN
          r_fy <= w_fy; r_fovf <= w_fsat;
`endif
          r_state <= S_ROUND;
        end
        S_ROUND: begin
          r_dz <= 1'b0; r_inv <= 1'b0; r_valid <= 1'b1; r_state <= S_DONE;
`ifdef FIX_FLOAT_DIV_FIXED_EN
          if (!w_flt) begin
            r_y <= r_fy; r_ovf <= r_fovf;
          end else
`endif
          begin
            r_y <= w_rnd_y; r_ovf <= w_rnd_ovf;
          end
        end
        S_DONE: begin
          r_ready <= 1'b1; r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ready_o = r_ready;
  assign valid_o = r_valid;
  assign y_o     = r_y;
  assign dz_o    = r_dz;
  assign inv_o   = r_inv;
  assign ovf_o   = r_ovf;
endmodule
